ones_window_accumulator: RTL and testbench

Downstream consumer of the ones counter. Accepts one popcount per valid handshake, sums WINDOW consecutive counts and presents the windowed sum with a threshold-decision flag over a valid/ready output handshake. Sits between the ones counter and the classification/decision logic, turning per-sample popcounts into a per-window activity score.

---
 rtl/ones_window_accumulator_if.sv | 63 ++++++
 rtl/ones_window_accumulator.sv | 149 ++++++++++++++
 tb/tb_ones_window_accumulator.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ones_window_accumulator_if.sv
// ---------------------------------------------------------------------------
// ones_window_accumulator_if
//
// Bundles the sample-in and result-out handshakes of ones_window_accumulator.
//
// Sample side (producer -> accumulator):
//   ones_i   popcount sample
//   valid_i  ones_i is valid this cycle
//   ready_o  accumulator accepts a sample this cycle
//   clear_i  synchronous abort of the partial window / pending result
//
// Result side (accumulator -> consumer):
//   sum_o    windowed sum
//   above_o  sum_o >= THRESHOLD
//   valid_o  sum_o/above_o hold a result
//   ready_i  consumer takes the result
//   count_o  samples accepted in the current window (debug)
//
// Modports: master = the side that feeds samples and consumes results,
//           slave  = the accumulator itself.
// ---------------------------------------------------------------------------
interface ones_window_accumulator_if #(
   parameter int INPUT_FEATURES = 8,
   parameter int WINDOW         = 4
);
   localparam int ONES_W = $clog2(INPUT_FEATURES + 1);
   localparam int SUM_W  = $clog2(INPUT_FEATURES * WINDOW + 1);
   localparam int CNT_W  = ($clog2(WINDOW + 1) > 1) ? $clog2(WINDOW + 1) : 1;

   logic [ONES_W-1:0] ones_i;
   logic              valid_i;
   logic              ready_o;
   logic              clear_i;
   logic [SUM_W-1:0]  sum_o;
   logic              above_o;
   logic              valid_o;
   logic              ready_i;
   logic [CNT_W-1:0]  count_o;

   modport master (
      output ones_i,
      output valid_i,
      input  ready_o,
      output clear_i,
      input  sum_o,
      input  above_o,
      input  valid_o,
      output ready_i,
      input  count_o
   );

   modport slave (
      input  ones_i,
      input  valid_i,
      output ready_o,
      input  clear_i,
      output sum_o,
      output above_o,
      output valid_o,
      input  ready_i,
      output count_o
   );
endinterface

// File: rtl/ones_window_accumulator.sv
// ---------------------------------------------------------------------------
// ones_window_accumulator
//
// Sums WINDOW consecutive accepted popcount samples and presents the sum,
// together with a ">= THRESHOLD" decision flag, over a valid/ready handshake.
//
// Ports:
//   clock_i  clock, rising edge
//   reset_i  asynchronous active-high reset
//   bus      ones_window_accumulator_if.slave
//              ones_i/valid_i/ready_o : sample input handshake
//              clear_i                : synchronous abort, highest priority
//              sum_o/above_o/valid_o/ready_i : result output handshake
//              count_o                : samples accepted in current window
//
// Two states: ACCUM takes samples, HOLD presents one result until taken.
// ready_o depends only on state (and reset), never on ready_i.
// ---------------------------------------------------------------------------
module ones_window_accumulator #(
   parameter int INPUT_FEATURES = 8,
   parameter int WINDOW         = 4,
   parameter int THRESHOLD      = 16
) (
   input logic                          clock_i,
   input logic                          reset_i,
   ones_window_accumulator_if.slave     bus
);

   localparam int ONES_W = $clog2(INPUT_FEATURES + 1);
   localparam int SUM_W  = $clog2(INPUT_FEATURES * WINDOW + 1);
   localparam int CNT_W  = ($clog2(WINDOW + 1) > 1) ? $clog2(WINDOW + 1) : 1;

   localparam logic [SUM_W-1:0] THR_SUM  = SUM_W'(THRESHOLD);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   // Out-of-range popcounts saturate at INPUT_FEATURES so the sum cannot
   // exceed INPUT_FEATURES*WINDOW and the accumulator never wraps.
   function automatic logic [SUM_W-1:0] clamp_ones(input logic [ONES_W-1:0] x);
      logic [SUM_W-1:0] r;
      if (x > ONES_W'(INPUT_FEATURES)) begin
         r = SUM_W'(INPUT_FEATURES);
      end else begin
         r = SUM_W'(x);
      end
      return r;
   endfunction

   state_t           state_q;
   state_t           state_d;
   logic [SUM_W-1:0] acc_p0;
   logic [CNT_W-1:0] cnt_p0;
   logic [SUM_W-1:0] sum_p1;
   logic             above_p1;

   logic             ready;
   logic             accept;
   logic             last_sample;
   logic [SUM_W-1:0] sample_sum;

   // ---- control: next state and handshake outputs ----
   always_comb begin
      state_d     = state_q;
      ready       = 1'b0;
      accept      = 1'b0;
      last_sample = 1'b0;
      sample_sum  = acc_p0 + clamp_ones(bus.ones_i);

      // With WINDOW=1 every sample closes the window; the counter stays 0.
      if (WINDOW == 1) begin
         last_sample = 1'b1;
      end else begin
         last_sample = (cnt_p0 == LAST_CNT);
      end

      case (state_q)
         ACCUM: begin
            ready  = !reset_i;
            // clear_i outranks an offered sample: the sample is dropped.
            accept = bus.valid_i && ready && !bus.clear_i;
            if (accept && last_sample) begin
               state_d = HOLD;
            end
         end
         HOLD: begin
            // A clear discards the result even if ready_i is also high.
            if (bus.clear_i || bus.ready_i) begin
               state_d = ACCUM;
            end
         end
         default: begin
            state_d = ACCUM;
         end
      endcase
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= ACCUM;
      end else begin
         state_q <= state_d;
      end
   end

   // ---- stage p0: running accumulator and sample count ----
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         acc_p0 <= '0;
         cnt_p0 <= '0;
      end else if (state_q == ACCUM) begin
         if (bus.clear_i) begin
            acc_p0 <= '0;
            cnt_p0 <= '0;
         end else if (accept) begin
            if (last_sample) begin
               acc_p0 <= '0;
               cnt_p0 <= '0;
            end else begin
               acc_p0 <= sample_sum;
               cnt_p0 <= cnt_p0 + CNT_W'(1);
            end
         end
      end
   end

   // ---- stage p1: registered window result and threshold decision ----
   // Captured on the edge that accepts the last sample, so the result is
   // visible one cycle after that accept; held untouched through HOLD.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         sum_p1   <= '0;
         above_p1 <= 1'b0;
      end else if (accept && last_sample) begin
         sum_p1   <= sample_sum;
         above_p1 <= (sample_sum >= THR_SUM);
      end
   end

   assign bus.ready_o = ready;
   assign bus.valid_o = (state_q == HOLD);
   assign bus.sum_o   = sum_p1;
   assign bus.above_o = above_p1;
   assign bus.count_o = cnt_p0;

endmodule

// File: tb/tb_ones_window_accumulator.sv
module tb_ones_window_accumulator;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   ones_window_accumulator_if #(.INPUT_FEATURES(8), .WINDOW(4)) bus ();

   ones_window_accumulator #(
      .INPUT_FEATURES (8),
      .WINDOW         (4),
      .THRESHOLD      (16)
   ) dut (
      .clock_i (clk),
      .reset_i (rst),
      .bus     (bus)
   );

   // Rising edges at 7, 17, 27, ... so the 15 ns reset release is mid-cycle.
   initial begin
      clk = 1'b0;
      #2;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one active edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] v);
      bus.ones_i  = v;
      bus.valid_i = 1'b1;
      step();
   endtask

   task automatic chk_result(input string tag, input int s, input int a);
      chk({tag, "_valid"}, 32'(bus.valid_o), 32'd1);
      chk({tag, "_sum"},   32'(bus.sum_o),   32'(s));
      chk({tag, "_above"}, 32'(bus.above_o), 32'(a));
      chk({tag, "_ready"}, 32'(bus.ready_o), 32'd0);
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      rst         = 1'b1;
      bus.ones_i  = '0;
      bus.valid_i = 1'b0;
      bus.clear_i = 1'b0;
      bus.ready_i = 1'b0;

      // 1: reset
      #10;
      chk("rst_ready", 32'(bus.ready_o), 32'd0);
      chk("rst_valid", 32'(bus.valid_o), 32'd0);
      chk("rst_sum",   32'(bus.sum_o),   32'd0);
      chk("rst_above", 32'(bus.above_o), 32'd0);
      chk("rst_count", 32'(bus.count_o), 32'd0);
      #5;
      rst = 1'b0;
      #1;
      chk("post_rst_ready", 32'(bus.ready_o), 32'd1);
      chk("post_rst_count", 32'(bus.count_o), 32'd0);
      @(negedge clk);

      // 2: 1,2,3,4 -> 10
      bus.ready_i = 1'b1;
      send(4'd1);
      chk("w1_cnt1", 32'(bus.count_o), 32'd1);
      chk("w1_nv1",  32'(bus.valid_o), 32'd0);
      send(4'd2);
      chk("w1_cnt2", 32'(bus.count_o), 32'd2);
      send(4'd3);
      chk("w1_cnt3", 32'(bus.count_o), 32'd3);
      send(4'd4);
      bus.valid_i = 1'b0;
      chk_result("w1", 10, 0);
      chk("w1_cnt0", 32'(bus.count_o), 32'd0);
      step();
      chk("w1_done_valid", 32'(bus.valid_o), 32'd0);
      chk("w1_done_ready", 32'(bus.ready_o), 32'd1);

      // 3: 8,8,0,8 -> 24 held while ready_i low and 5s offered
      bus.ready_i = 1'b0;
      send(4'd8);
      send(4'd8);
      send(4'd0);
      send(4'd8);
      bus.ones_i = 4'd5;
      chk_result("w2", 24, 1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk_result("w2_hold", 24, 1);
         chk("w2_hold_cnt", 32'(bus.count_o), 32'd0);
      end
      bus.ready_i = 1'b1;
      step();
      bus.valid_i = 1'b0;
      chk("w2_rel_valid", 32'(bus.valid_o), 32'd0);
      chk("w2_rel_ready", 32'(bus.ready_o), 32'd1);
      chk("w2_rel_cnt",   32'(bus.count_o), 32'd0);

      // 4: 4 on alternate cycles -> 16 (boundary), then 4,4,4,3 -> 15
      bus.ready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send(4'd4);
         if (i < 3) begin
            bus.valid_i = 1'b0;
            step();
            chk("w3_gap_cnt", 32'(bus.count_o), 32'(i + 1));
         end
      end
      bus.valid_i = 1'b0;
      chk_result("w3", 16, 1);
      bus.ready_i = 1'b1;
      step();
      bus.ready_i = 1'b0;
      send(4'd4);
      send(4'd4);
      send(4'd4);
      send(4'd3);
      bus.valid_i = 1'b0;
      chk_result("w4", 15, 0);
      bus.ready_i = 1'b1;
      step();

      // 5: clear mid-window drops the simultaneous 7
      bus.ready_i = 1'b0;
      send(4'd3);
      send(4'd3);
      chk("w5_cnt2", 32'(bus.count_o), 32'd2);
      bus.clear_i = 1'b1;
      send(4'd7);
      bus.clear_i = 1'b0;
      chk("w5_clr_cnt",   32'(bus.count_o), 32'd0);
      chk("w5_clr_ready", 32'(bus.ready_o), 32'd1);
      chk("w5_clr_valid", 32'(bus.valid_o), 32'd0);
      for (int i = 0; i < 4; i++) send(4'd1);
      bus.valid_i = 1'b0;
      chk_result("w5", 4, 0);

      // clear in HOLD discards result even with ready_i high; sum_o kept
      bus.clear_i = 1'b1;
      bus.ready_i = 1'b1;
      step();
      bus.clear_i = 1'b0;
      bus.ready_i = 1'b0;
      chk("hold_clr_valid", 32'(bus.valid_o), 32'd0);
      chk("hold_clr_ready", 32'(bus.ready_o), 32'd1);
      chk("hold_clr_sum",   32'(bus.sum_o),   32'd4);

      // 6: out-of-range 15 clamps to 8 -> 32, then async reset in HOLD
      for (int i = 0; i < 4; i++) send(4'd15);
      bus.valid_i = 1'b0;
      chk_result("w6", 32, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid", 32'(bus.valid_o), 32'd0);
      chk("arst_sum",   32'(bus.sum_o),   32'd0);
      chk("arst_above", 32'(bus.above_o), 32'd0);
      chk("arst_ready", 32'(bus.ready_o), 32'd0);
      #10;
      rst = 1'b0;
      #2;
      chk("arst_rel_ready", 32'(bus.ready_o), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   // Bound the run in case the stimulus sequence stalls.
   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
